// File: rtl/video_timing_gen.sv
// Raster timing generator for the HDMI transmit path: pixel/line counters plus
// registered framing flags (blanking, {vsync, hsync}, early-active, line/frame start).
module video_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter logic        H_SYNC_POL = 1'b0,
  parameter logic        V_SYNC_POL = 1'b0
) (
  input  logic        pix_clock,
  input  logic        reset,
  input  logic        enable,
  output logic [11:0] h_count,
  output logic [10:0] v_count,
  output logic        active,
  output logic        blanking,
  output logic [1:0]  control_data,
  output logic        next_active,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned HW = 12;
  localparam int unsigned VW = 11;

  localparam int unsigned H_TOTAL        = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL        = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START_I = H_ACTIVE + H_FRONT;
  localparam int unsigned H_SYNC_END_I   = H_SYNC_START_I + H_SYNC;
  localparam int unsigned V_SYNC_START_I = V_ACTIVE + V_FRONT;
  localparam int unsigned V_SYNC_END_I   = V_SYNC_START_I + V_SYNC;

  if (H_TOTAL > 4096 || V_TOTAL > 2048 ||
      H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_params
    $error("video_timing_gen: invalid timing parameters");
  end

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_SYNC_START_I);
  localparam logic [HW-1:0] H_SE   = HW'(H_SYNC_END_I);
  localparam logic [VW-1:0] V_SS   = VW'(V_SYNC_START_I);
  localparam logic [VW-1:0] V_SE   = VW'(V_SYNC_END_I);

  function automatic logic [HW-1:0] h_next(input logic [HW-1:0] h);
    return (h == H_LAST) ? '0 : h + HW'(1);
  endfunction

  function automatic logic [VW-1:0] v_next(input logic [HW-1:0] h, input logic [VW-1:0] v);
    if (h != H_LAST) return v;
    return (v == V_LAST) ? '0 : v + VW'(1);
  endfunction

  function automatic logic in_active(input logic [HW-1:0] h, input logic [VW-1:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  logic [HW-1:0] h_count_q, h_count_d, h_succ;
  logic [VW-1:0] v_count_q, v_count_d, v_succ;
  logic          active_q, active_d;
  logic          blanking_q, blanking_d;
  logic [1:0]    control_data_q, control_data_d;
  logic          next_active_q, next_active_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          hsync_on, vsync_on;

  // Flags decode the position the counters are about to hold, so they never skew.
  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (enable) begin
      h_count_d = h_next(h_count_q);
      v_count_d = v_next(h_count_q, v_count_q);
    end

    h_succ   = h_next(h_count_d);
    v_succ   = v_next(h_count_d, v_count_d);
    hsync_on = (h_count_d >= H_SS) && (h_count_d < H_SE);
    vsync_on = (v_count_d >= V_SS) && (v_count_d < V_SE);

    active_d       = in_active(h_count_d, v_count_d);
    blanking_d     = ~active_d;
    control_data_d = {vsync_on ? V_SYNC_POL : ~V_SYNC_POL,
                      hsync_on ? H_SYNC_POL : ~H_SYNC_POL};
    next_active_d  = in_active(h_succ, v_succ);
    line_start_d   = (h_count_d == '0);
    frame_start_d  = line_start_d && (v_count_d == '0);
  end

  // Reset parks on the last frame position so the first enabled edge lands on (0,0).
  always_ff @(posedge pix_clock) begin
    if (reset) begin
      h_count_q      <= H_LAST;
      v_count_q      <= V_LAST;
      active_q       <= 1'b0;
      blanking_q     <= 1'b1;
      control_data_q <= {~V_SYNC_POL, ~H_SYNC_POL};
      next_active_q  <= 1'b1;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      h_count_q      <= h_count_d;
      v_count_q      <= v_count_d;
      active_q       <= active_d;
      blanking_q     <= blanking_d;
      control_data_q <= control_data_d;
      next_active_q  <= next_active_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign h_count      = h_count_q;
  assign v_count      = v_count_q;
  assign active       = active_q;
  assign blanking     = blanking_q;
  assign control_data = control_data_q;
  assign next_active  = next_active_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: 640x480 default timing plus two small
// rasters (active-low and active-high syncs) so whole frames fit in a short run.
module tb_video_timing_gen;

  logic pix_clock = 1'b0;
  always #5 pix_clock = ~pix_clock;

  int vectors     = 0;
  int miscompares = 0;

  // DUT A: default 800x525 raster
  logic        rst_a, en_a;
  logic [11:0] a_h;
  logic [10:0] a_v;
  logic        a_act, a_blank, a_na, a_ls, a_fs;
  logic [1:0]  a_cd;

  video_timing_gen dut_a (
    .pix_clock(pix_clock), .reset(rst_a), .enable(en_a),
    .h_count(a_h), .v_count(a_v), .active(a_act), .blanking(a_blank),
    .control_data(a_cd), .next_active(a_na), .line_start(a_ls), .frame_start(a_fs));

  // DUT B: 25x13 raster, active-low syncs. hsync h=18..20, vsync v=8..9.
  logic        rst_b, en_b;
  logic [11:0] b_h;
  logic [10:0] b_v;
  logic        b_act, b_blank, b_na, b_ls, b_fs;
  logic [1:0]  b_cd;

  video_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_ACTIVE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_b (
    .pix_clock(pix_clock), .reset(rst_b), .enable(en_b),
    .h_count(b_h), .v_count(b_v), .active(b_act), .blanking(b_blank),
    .control_data(b_cd), .next_active(b_na), .line_start(b_ls), .frame_start(b_fs));

  // DUT C: 17x10 raster, active-high syncs. hsync h=10..13, vsync v=5..7.
  logic        rst_c, en_c;
  logic [11:0] c_h;
  logic [10:0] c_v;
  logic        c_act, c_blank, c_na, c_ls, c_fs;
  logic [1:0]  c_cd;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(3), .V_BACK(2),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_c (
    .pix_clock(pix_clock), .reset(rst_c), .enable(en_c),
    .h_count(c_h), .v_count(c_v), .active(c_act), .blanking(c_blank),
    .control_data(c_cd), .next_active(c_na), .line_start(c_ls), .frame_start(c_fs));

  // Record layout: {h[11:0], v[10:0], active, blanking, control_data[1:0], next_active, line_start, frame_start}
  typedef struct packed {
    logic        rst;
    logic        en;
    logic [11:0] h;
    logic [10:0] v;
    logic        act;
    logic        blank;
    logic [1:0]  cd;
    logic        na;
    logic        ls;
    logic        fs;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [29:0] snap_a();
    return {a_h, a_v, a_act, a_blank, a_cd, a_na, a_ls, a_fs};
  endfunction
  function automatic logic [29:0] snap_b();
    return {b_h, b_v, b_act, b_blank, b_cd, b_na, b_ls, b_fs};
  endfunction
  function automatic logic [29:0] snap_c();
    return {c_h, c_v, c_act, c_blank, c_cd, c_na, c_ls, c_fs};
  endfunction

  task automatic tick();
    @(posedge pix_clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  int   act_cnt, act_last, blank_bad, hs_cnt, hs_first, hs_last, vs_cnt, ls_cnt;
  int   na_fall, na_rise, flen, last_h, last_v, act_bad, vs_first, vs_last, vs_midline;
  logic na_prev, na_799_0, vs_prev;
  logic [29:0] snap;
  bit   done;

  initial begin
    rst_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1;
    rst_c = 1'b1; en_c = 1'b1;

    tbl[0] = '{1'b1, 1'b1, 12'd799, 11'd524, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 12'd799, 11'd524, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 12'd799, 11'd524, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 12'd0,   11'd0,   1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 12'd1,   11'd0,   1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 12'd1,   11'd0,   1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 12'd2,   11'd0,   1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0};

    // Reset, first frame entry and a one-cycle stall on the default raster
    for (int i = 0; i < 7; i++) begin
      rst_a = tbl[i].rst;
      en_a  = tbl[i].en;
      tick();
      check($sformatf("tbl_%0d", i), 32'(snap_a()), 32'(tbl[i][29:0]));
    end

    // Walk the rest of line 0 and all of line 1 on the default raster
    act_cnt = 0; act_last = -1; blank_bad = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    vs_cnt = 0; ls_cnt = 0; na_fall = -1; na_rise = -1; na_799_0 = 1'b0; done = 0;
    na_prev = a_na;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick();
      if (a_v == 11'd0 && a_h == 12'd799) na_799_0 = a_na;
      if (a_v == 11'd1) begin
        if (a_act) begin act_cnt++; act_last = int'(a_h); end
        if (a_blank !== ~a_act) blank_bad++;
        if (!a_cd[0]) begin
          if (hs_first < 0) hs_first = int'(a_h);
          hs_last = int'(a_h);
          hs_cnt++;
        end
        if (!a_cd[1]) vs_cnt++;
        if (a_ls) ls_cnt++;
        if (na_prev && !a_na && na_fall < 0) na_fall = int'(a_h);
        if (!na_prev && a_na && na_rise < 0) na_rise = int'(a_h);
        if (a_h == 12'd799) done = 1;
      end
      na_prev = a_na;
    end
    check("a_line_reached",  32'(done), 32'd1);
    check("a_active_count",  32'(act_cnt), 32'd640);
    check("a_active_last_h", 32'(act_last), 32'd639);
    check("a_blank_inverse", 32'(blank_bad), 32'd0);
    check("a_hsync_count",   32'(hs_cnt), 32'd96);
    check("a_hsync_first_h", 32'(hs_first), 32'd656);
    check("a_hsync_last_h",  32'(hs_last), 32'd751);
    check("a_vsync_line1",   32'(vs_cnt), 32'd0);
    check("a_line_start",    32'(ls_cnt), 32'd1);
    check("a_next_act_fall", 32'(na_fall), 32'd639);
    check("a_next_act_rise", 32'(na_rise), 32'd799);
    check("a_next_act_799_0", 32'(na_799_0), 32'd1);

    // Small raster B: reset park, first edge, full-frame measurement
    tick();
    check("b_park", 32'(snap_b()), 32'({12'd24, 11'd12, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0}));
    rst_b = 1'b0;
    tick();
    check("b_first", 32'(snap_b()), 32'({12'd0, 11'd0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1}));

    flen = 0; act_cnt = 0; act_bad = 0; blank_bad = 0; hs_cnt = 0; hs_first = 99; hs_last = -1;
    vs_cnt = 0; vs_first = -1; vs_last = -1; last_h = -1; last_v = -1; done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      flen++;
      if (b_act) act_cnt++;
      if (b_act && b_v >= 11'd6) act_bad++;
      if (b_blank !== ~b_act) blank_bad++;
      if (!b_cd[0]) begin
        hs_cnt++;
        if (int'(b_h) < hs_first) hs_first = int'(b_h);
        if (int'(b_h) > hs_last) hs_last = int'(b_h);
      end
      if (!b_cd[1]) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = int'(b_v) * 100 + int'(b_h);
        vs_last = int'(b_v) * 100 + int'(b_h);
      end
      last_h = int'(b_h); last_v = int'(b_v);
      tick();
      if (b_fs) done = 1;
    end
    check("b_frame_wrapped", 32'(done), 32'd1);
    check("b_frame_length",  32'(flen), 32'd325);
    check("b_last_pos",      32'(last_v * 100 + last_h), 32'(12 * 100 + 24));
    check("b_wrap_pos",      32'({b_h, b_v, b_ls}), 32'({12'd0, 11'd0, 1'b1}));
    check("b_active_count",  32'(act_cnt), 32'd96);
    check("b_vblank_active", 32'(act_bad), 32'd0);
    check("b_blank_inverse", 32'(blank_bad), 32'd0);
    check("b_hsync_count",   32'(hs_cnt), 32'd39);
    check("b_hsync_range",   32'(hs_first * 100 + hs_last), 32'(18 * 100 + 20));
    check("b_vsync_count",   32'(vs_cnt), 32'd50);
    check("b_vsync_first",   32'(vs_first), 32'(8 * 100 + 0));
    check("b_vsync_last",    32'(vs_last), 32'(9 * 100 + 24));

    // Stall one pixel before hsync starts
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (b_h == 12'd17 && b_v == 11'd7) done = 1;
      else tick();
    end
    check("b_stall1_reached", 32'(done), 32'd1);
    snap = snap_b();
    en_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("b_stall1_hold_%0d", i), 32'(snap_b()), 32'(snap));
    end
    en_b = 1'b1;
    tick();
    check("b_stall1_resume", 32'({b_h, b_v, b_cd}), 32'({12'd18, 11'd7, 2'b10}));

    // Stall on the frame-start position
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (b_fs) done = 1;
    end
    check("b_stall0_reached", 32'(done), 32'd1);
    snap = snap_b();
    en_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("b_stall0_hold_%0d", i), 32'(snap_b()), 32'(snap));
    end
    check("b_stall0_fs_held", 32'({b_h, b_v, b_fs}), 32'({12'd0, 11'd0, 1'b1}));
    en_b = 1'b1;
    tick();
    check("b_stall0_resume", 32'({b_h, b_v, b_act, b_ls, b_fs}), 32'({12'd1, 11'd0, 1'b1, 1'b0, 1'b0}));

    // One-cycle reset mid-frame
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (b_h == 12'd10 && b_v == 11'd4) done = 1;
      else tick();
    end
    check("b_midreset_reached", 32'(done), 32'd1);
    rst_b = 1'b1;
    tick();
    check("b_midreset_park", 32'(snap_b()), 32'({12'd24, 11'd12, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0}));
    rst_b = 1'b0;
    tick();
    check("b_midreset_first", 32'(snap_b()), 32'({12'd0, 11'd0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1}));

    // Small raster C with active-high syncs
    tick();
    check("c_park", 32'(snap_c()), 32'({12'd16, 11'd9, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0}));
    rst_c = 1'b0;
    tick();
    check("c_first", 32'(snap_c()), 32'({12'd0, 11'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1}));

    flen = 0; hs_cnt = 0; hs_first = 99; hs_last = -1; vs_cnt = 0; vs_first = 99; vs_last = -1;
    vs_midline = 0; vs_prev = c_cd[1]; done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      flen++;
      if (c_cd[0]) begin
        hs_cnt++;
        if (int'(c_h) < hs_first) hs_first = int'(c_h);
        if (int'(c_h) > hs_last) hs_last = int'(c_h);
      end
      if (c_cd[1]) begin
        vs_cnt++;
        if (int'(c_v) < vs_first) vs_first = int'(c_v);
        if (int'(c_v) > vs_last) vs_last = int'(c_v);
      end
      if (c_cd[1] !== vs_prev && c_h != 12'd0) vs_midline++;
      vs_prev = c_cd[1];
      tick();
      if (c_fs) done = 1;
    end
    check("c_frame_wrapped", 32'(done), 32'd1);
    check("c_frame_length",  32'(flen), 32'd170);
    check("c_hsync_count",   32'(hs_cnt), 32'd40);
    check("c_hsync_range",   32'(hs_first * 100 + hs_last), 32'(10 * 100 + 13));
    check("c_vsync_count",   32'(vs_cnt), 32'd51);
    check("c_vsync_range",   32'(vs_first * 100 + vs_last), 32'(5 * 100 + 7));
    check("c_vsync_midline", 32'(vs_midline), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
